// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C transaction arbiter: FSM states and rw codes.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam logic RW_WR = 1'b1;
  localparam logic RW_RD = 1'b0;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester/engine signal bundle for i2c_arbiter; slave = arbiter view,
// master = the side driving requests and engine status.
interface i2c_arbiter_if #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_rw;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_reg;
  logic [8*NREQ-1:0] req_wdata;

  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_ack;
  logic              rsp_err;
  logic [7:0]        rsp_rdata;

  logic              eng_start;
  logic              eng_rw;
  logic [6:0]        eng_addr;
  logic [7:0]        eng_reg;
  logic [7:0]        eng_txd;

  logic              eng_done;
  logic              eng_ack;
  logic              eng_busy;
  logic [7:0]        eng_rxd;

  modport slave (
    input  req, req_rw, req_addr, req_reg, req_wdata,
    input  eng_done, eng_ack, eng_busy, eng_rxd,
    output rsp_valid, rsp_ack, rsp_err, rsp_rdata,
    output eng_start, eng_rw, eng_addr, eng_reg, eng_txd
  );

  modport master (
    output req, req_rw, req_addr, req_reg, req_wdata,
    output eng_done, eng_ack, eng_busy, eng_rxd,
    input  rsp_valid, rsp_ack, rsp_err, rsp_rdata,
    input  eng_start, eng_rw, eng_addr, eng_reg, eng_txd
  );

endinterface

// File: rtl/i2c_rr_arb.sv
// Combinational round-robin grant: search starts one past the last grant.
module i2c_rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last_grant,
  output logic [NREQ-1:0] o_grant_oh,
  output logic [IW-1:0]   o_grant_idx,
  output logic            o_any
);

  int w_cand;

  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_cand      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = (int'(i_last_grant) + i) % NREQ;
      if (!o_any && i_req[w_cand]) begin
        o_any              = 1'b1;
        o_grant_idx        = IW'(w_cand);
        o_grant_oh[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C register-access engine among NREQ requesters.
// Optional engine-completion timeout is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic          clk,
  input logic          reset_n,
  i2c_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_last_grant;
  logic [IW-1:0]   r_grant_idx;
  logic [NREQ-1:0] r_grant_oh;
  logic            r_eng_start;
  logic            r_eng_rw;
  logic [6:0]      r_eng_addr;
  logic [7:0]      r_eng_reg;
  logic [7:0]      r_eng_txd;
  logic            r_rsp_ack;
  logic            r_rsp_err;
  logic [7:0]      r_rsp_rdata;
  logic            r_done_q1;
  logic            r_done_q2;

  logic [NREQ-1:0] w_grant_oh;
  logic [IW-1:0]   w_grant_idx;
  logic            w_any;
  logic            w_done_edge;
  logic            w_timeout;
  logic            w_unused;

  i2c_rr_arb #(.NREQ(NREQ), .IW(IW)) u_rr_arb (
    .i_req        (bus.req),
    .i_last_grant (r_last_grant),
    .o_grant_oh   (w_grant_oh),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_any)
  );

  // Two-stage sample so a done already high when the wait begins never looks like an edge.
  assign w_done_edge = r_done_q1 & ~r_done_q2;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;

  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == WAIT_DONE && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_unused = bus.eng_busy ^ (TIMEOUT_CYC > 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_any) w_next = ISSUE;
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: if (w_done_edge || w_timeout) w_next = RESP;
      RESP:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done_q1 <= 1'b0;
      r_done_q2 <= 1'b0;
    end else begin
      r_done_q1 <= bus.eng_done;
      r_done_q2 <= r_done_q1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= IW'(NREQ - 1);
      r_grant_idx  <= '0;
      r_grant_oh   <= '0;
      r_eng_start  <= 1'b1;
      r_eng_rw     <= 1'b0;
      r_eng_addr   <= '0;
      r_eng_reg    <= '0;
      r_eng_txd    <= '0;
      r_rsp_ack    <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_idx <= w_grant_idx;
            r_grant_oh  <= w_grant_oh;
            r_eng_rw    <= bus.req_rw[w_grant_idx];
            r_eng_addr  <= bus.req_addr[7*int'(w_grant_idx) +: 7];
            r_eng_reg   <= bus.req_reg[8*int'(w_grant_idx) +: 8];
            r_eng_txd   <= bus.req_wdata[8*int'(w_grant_idx) +: 8];
            r_eng_start <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (w_done_edge) begin
            r_eng_start <= 1'b1;
            r_rsp_ack   <= bus.eng_ack;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= (r_eng_rw == RW_RD) ? bus.eng_rxd : 8'h00;
          end else if (w_timeout) begin
            r_eng_start <= 1'b1;
            r_rsp_ack   <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 8'h00;
          end
        end
        RESP: begin
          r_last_grant <= r_grant_idx;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (r_state == RESP) ? r_grant_oh : '0;
  assign bus.rsp_ack   = r_rsp_ack;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.rsp_err   = r_rsp_err;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.eng_start = r_eng_start;
  assign bus.eng_rw    = r_eng_rw;
  assign bus.eng_addr  = r_eng_addr;
  assign bus.eng_reg   = r_eng_reg;
  assign bus.eng_txd   = r_eng_txd;

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, the number of requesters (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, the maximum cycles to wait for engine completion.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port req, input, NREQ, per-requester transaction request (level).
REQ-007 SHALL have ports req_rw, input, NREQ; req_addr, input, 7*NREQ; req_reg, input, 8*NREQ; req_wdata, input, 8*NREQ; these carry per-requester rw (1=write), slave address, slave register and write byte.
REQ-008 SHALL have port rsp_valid, output, NREQ, a one-cycle completion pulse for the served requester.
REQ-009 SHALL have ports rsp_ack, output, 1; rsp_err, output, 1; rsp_rdata, output, 8; these carry the shared response, valid with rsp_valid.
REQ-010 SHALL have ports eng_start, output, 1, engine start (active-low, idle 1); eng_rw, output, 1; eng_addr, output, 7; eng_reg, output, 8; eng_txd, output, 8.
REQ-011 SHALL have ports eng_done, input, 1; eng_ack, input, 1; eng_busy, input, 1; eng_rxd, input, 8; these are the engine status and read data.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE, RESP.
REQ-013 SHALL, in IDLE with any req bit high, grant round-robin starting at (last_grant+1) mod NREQ, latch the granted rw/addr/reg/wdata into eng_* registers, and go to ISSUE next cycle.
REQ-014 SHALL, in ISSUE, drive eng_start=0, clear the timeout counter, and go to WAIT_DONE.
REQ-015 SHALL, in WAIT_DONE, hold eng_start=0 and eng_* stable until a 0->1 edge of eng_done (registered edge detect; a done already high on entry is ignored).
REQ-016 SHALL, on the eng_done edge, release eng_start=1, capture eng_ack and eng_rxd (the latter only when rw=0, else 0), set rsp_err=0, and go to RESP.
REQ-017 SHALL, in RESP, pulse rsp_valid[grant] for exactly one cycle, update last_grant=grant, and return to IDLE; issue-to-response latency SHALL be engine time plus 3 cycles.
REQ-018 SHALL ignore req changes while not in IDLE; a requester whose req drops mid-transaction still receives its rsp_valid.
REQ-019 SHALL NOT grant a new request in the RESP cycle; a requester holding req high after its rsp_valid is re-arbitrated fairly.
REQ-020 SHALL hold rsp_ack/rsp_err/rsp_rdata until the next RESP.

Reset
REQ-021 SHALL, on reset_n=0 (asynchronously, including mid-transaction), set the state to IDLE, eng_start=1, eng_rw/addr/reg/txd=0, rsp_valid=0, rsp_ack=0, rsp_err=0, rsp_rdata=0, last_grant=NREQ-1 (so requester 0 wins first), and the timeout counter to 0.

Configuration
REQ-022 SHALL, with I2C_ARB_TIMEOUT_EN defined, abort WAIT_DONE when the counter reaches TIMEOUT_CYC: eng_start=1, rsp_err=1, rsp_ack=0, rsp_rdata=0, go to RESP.
REQ-023 SHALL, without I2C_ARB_TIMEOUT_EN, contain no counter, wait indefinitely in WAIT_DONE, and tie rsp_err to 0.

Structure
REQ-024 SHALL place the FSM state encoding and the rw encoding constants (WR=1, RD=0) in shared package i2c_pkg.
REQ-025 SHALL implement the grant logic as sub-module i2c_rr_arb (req, last_grant -> one-hot grant plus index); there SHALL be no other sub-modules.

Verification
REQ-026 SHALL verify single write: req=01, rw=1, addr=0x50, reg=0x10, wdata=0xA5; engine done after 40 cycles with ack=1 -> eng_* match, eng_start low for the whole wait, rsp_valid=01 one cycle, rsp_ack=1, rsp_rdata=0x00.
REQ-027 SHALL verify read: requester 1 rw=0, eng_rxd=0x3C -> rsp_valid=10, rsp_rdata=0x3C, rsp_ack=1.
REQ-028 SHALL verify fairness: req=11 held continuously for 4 transactions -> grant order 0,1,0,1.
REQ-029 SHALL verify stale done: eng_done already high at ISSUE, falling then rising 20 cycles later -> completion only on the rising edge.
REQ-030 SHALL verify timeout (macro on, TIMEOUT_CYC=100): engine never signals done -> rsp_valid at 100+3 cycles with rsp_err=1 and eng_start back to 1.
REQ-031 SHALL verify reset mid-WAIT_DONE: reset_n low for 1 cycle -> state IDLE, eng_start=1, no rsp_valid; the next req=10 is served first.
